// File: rtl/spi_dda_pkg.sv
// Shared constants and FSM state type for the DDA SPI host.
package spi_dda_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned HALF_MIN = 4;
  localparam int unsigned GAP_MIN  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StTrail,
    StGap
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Interval tick generator: counts 0..limit_i and pulses tick_o on the last count.
module spi_clk_div #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic [CntW-1:0] limit_i,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_dda_host.sv
// Mode-0 SPI host for the DDA peripheral: one 32-bit frame per start, MSB first,
// command out on MOSI and {x, y} state word captured from MISO.
module spi_dda_host
  import spi_dda_pkg::*;
#(
  parameter int unsigned HALF = 8,
  parameter int unsigned GAP  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] tx_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] rx_data_o,
  output logic               cs_n_o,
  output logic               sclk_o,
  output logic               mosi_o,
  input  logic               miso_i
);

  localparam int unsigned CntMax = (HALF > GAP) ? HALF : GAP;
  localparam int unsigned CntW   = $clog2(CntMax);

  if (HALF < HALF_MIN) begin : g_half_chk
    $fatal(1, "spi_dda_host: HALF below HALF_MIN");
  end
  if (GAP < GAP_MIN) begin : g_gap_chk
    $fatal(1, "spi_dda_host: GAP below GAP_MIN");
  end

  state_e state_q, state_d;

  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic               miso_meta_q, miso_sync_q;

  logic            tick;
  logic [CntW-1:0] limit;
  logic            rise, fall, last_bit;

  // The divider sits cleared in IDLE so LEAD always starts from count 0.
  assign limit = (state_q == StGap) ? CntW'(GAP - 1) : CntW'(HALF - 1);

  spi_clk_div #(
    .CntW(CntW)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == StIdle),
    .limit_i(limit),
    .tick_o (tick)
  );

  assign last_bit = (bit_cnt_q == 6'd31);
  assign rise     = tick && ((state_q == StLead) || (state_q == StShift && !sclk_q));
  assign fall     = tick && (state_q == StShift) && sclk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLead;
      StLead:  if (tick) state_d = StShift;
      StShift: if (fall && last_bit) state_d = StTrail;
      StTrail: if (tick) state_d = StGap;
      StGap:   if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    if (state_q == StIdle) begin
      bit_cnt_d = '0;
      if (start_i) begin
        tx_shift_d = tx_data_i;
        mosi_d     = tx_data_i[FRAME_W-1];
        cs_n_d     = 1'b0;
      end
    end
    if (rise) begin
      sclk_d     = 1'b1;
      rx_shift_d = {rx_shift_q[FRAME_W-2:0], miso_sync_q};
    end
    if (fall) begin
      sclk_d     = 1'b0;
      bit_cnt_d  = bit_cnt_q + 6'd1;
      tx_shift_d = tx_shift_q << 1;
      // The final bit stays on MOSI until the frame is fully retired.
      if (!last_bit) begin
        mosi_d = tx_shift_q[FRAME_W-2];
      end
    end
    if (state_q == StTrail && tick) begin
      cs_n_d    = 1'b1;
      done_d    = 1'b1;
      rx_data_d = rx_shift_q;
    end
    if (state_q == StGap && tick) begin
      mosi_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_meta_q <= miso_i;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign cs_n_o    = cs_n_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_dda_host.sv
// Bench for spi_dda_host: loopback and a behavioural DDA peripheral on a HALF=8 instance,
// loopback timing sweep on a HALF=4 instance.
module tb_spi_dda_host;

  localparam int H8 = 8, G8 = 16, H4 = 4, G4 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, start4, busy8, busy4, done8, done4;
  logic [31:0] tx8, tx4, rx8, rx4;
  logic        cs8, cs4, sclk8, sclk4, mosi8, mosi4, miso8, miso4;
  logic        p_miso;
  bit          peri_mode, use4;

  spi_dda_host #(.HALF(H8), .GAP(G8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .tx_data_i(tx8), .busy_o(busy8),
    .done_o(done8), .rx_data_o(rx8), .cs_n_o(cs8), .sclk_o(sclk8), .mosi_o(mosi8),
    .miso_i(miso8)
  );

  spi_dda_host #(.HALF(H4), .GAP(G4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .tx_data_i(tx4), .busy_o(busy4),
    .done_o(done4), .rx_data_o(rx4), .cs_n_o(cs4), .sclk_o(sclk4), .mosi_o(mosi4),
    .miso_i(miso4)
  );

  assign miso4 = mosi4;
  assign miso8 = peri_mode ? p_miso : mosi8;

  logic        m_busy, m_done, m_cs, m_sclk, m_mosi;
  logic [31:0] m_rx;
  assign m_busy = use4 ? busy4 : busy8;
  assign m_done = use4 ? done4 : done8;
  assign m_cs   = use4 ? cs4 : cs8;
  assign m_sclk = use4 ? sclk4 : sclk8;
  assign m_mosi = use4 ? mosi4 : mosi8;
  assign m_rx   = use4 ? rx4 : rx8;

  // DDA peripheral: 3-flop input synchronisers, MISO shifted on falling SCLK,
  // MOSI captured on rising SCLK, mu taken from the low half when CS returns high.
  logic [3:0]  p_cs, p_sclk;
  logic [2:0]  p_mosi;
  logic [31:0] p_out, p_in, p_word;
  logic [15:0] p_mu;
  int          p_cs_falls;

  always @(posedge clk) begin
    if (!rst_n) begin
      p_cs   <= 4'hF;
      p_sclk <= 4'h0;
      p_mosi <= 3'h0;
      p_miso <= 1'b0;
    end else begin
      p_cs   <= {p_cs[2:0], cs8};
      p_sclk <= {p_sclk[2:0], sclk8};
      p_mosi <= {p_mosi[1:0], mosi8};
      if (p_cs[3] && !p_cs[2]) begin
        p_cs_falls <= p_cs_falls + 1;
        p_out      <= p_word;
        p_miso     <= p_word[31];
      end else if (!p_cs[2]) begin
        if (p_sclk[2] && !p_sclk[3]) p_in <= {p_in[30:0], p_mosi[2]};
        if (!p_sclk[2] && p_sclk[3]) begin
          p_out  <= p_out << 1;
          p_miso <= p_out[30];
        end
      end
      if (!p_cs[3] && p_cs[2]) p_mu <= p_in[15:0];
    end
  end

  int n_vec, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame; all times are relative to the cycle the start is accepted in.
  task automatic frame_and_check(input bit sel4, input logic [31:0] tx, input bit peri,
                                 input logic [31:0] word, input logic [31:0] exp_rx);
    int h, g, t_done, n_done, t_csf, t_idle, rises, falls0;
    logic prev_sclk, prev_cs, mosi_done, mosi_idle;
    logic [31:0] rx;
    h = sel4 ? H4 : H8;
    g = sel4 ? G4 : G8;
    use4 = sel4;
    peri_mode = peri;
    p_word = word;
    falls0 = p_cs_falls;
    t_done = -1; n_done = 0; t_csf = -1; t_idle = -1; rises = 0;
    prev_sclk = 1'b0; prev_cs = 1'b1; mosi_done = 1'bx; mosi_idle = 1'bx; rx = 'x;
    @(negedge clk);
    if (sel4) begin start4 = 1'b1; tx4 = tx; end
    else begin start8 = 1'b1; tx8 = tx; end
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
      if (m_sclk && !prev_sclk) rises++;
      if (!m_cs && prev_cs && t_csf < 0) t_csf = n;
      prev_sclk = m_sclk;
      prev_cs = m_cs;
      if (m_done) begin
        n_done++;
        if (t_done < 0) begin t_done = n; rx = m_rx; mosi_done = m_mosi; end
      end
      if (!m_busy) begin t_idle = n; mosi_idle = m_mosi; break; end
    end
    check("rx_data", rx, exp_rx);
    check("cs_fall_cycle", t_csf, 1);
    check("done_cycle", t_done, 1 + 65 * h);
    check("done_count", n_done, 1);
    check("sclk_rises", rises, 32);
    check("busy_low_cycle", t_idle, 1 + 65 * h + g);
    check("mosi_hold_last", mosi_done, tx[0]);
    check("mosi_idle", mosi_idle, 1'b0);
    if (peri) begin
      check("peri_mu", p_mu, tx[15:0]);
      check("peri_cs_falls", p_cs_falls - falls0, 1);
    end
  endtask

  typedef struct {
    logic [31:0] tx;
    bit          peri;
    logic [31:0] word;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nd, ncs, csf2, d2, lo1, lo2, bad;
    logic prev_cs;
    logic [31:0] t, w;
    bit pm;

    vecs[0] = '{32'hA5C3_0F81, 1'b0, 32'h0, 32'hA5C3_0F81};
    vecs[1] = '{32'h0000_4000, 1'b1, 32'h3000_3000, 32'h3000_3000};
    vecs[2] = '{32'h0000_0000, 1'b0, 32'h0, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFF};
    vecs[4] = '{32'h8000_0001, 1'b0, 32'h0, 32'h8000_0001};
    vecs[5] = '{32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    n_vec = 0; n_bad = 0; p_cs_falls = 0; p_in = 0; p_out = 0; p_mu = 0;
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; tx8 = '0; tx4 = '0;
    peri_mode = 1'b0; use4 = 1'b0; p_word = '0;
    // Start requested during reset must be ignored.
    @(negedge clk);
    start8 = 1'b1;
    tx8 = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    start8 = 1'b0;
    check("rst_cs_n", cs8, 1'b1);
    check("rst_sclk", sclk8, 1'b0);
    check("rst_mosi", mosi8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_rx_data", rx8, 32'h0);
    check("rst_cs_n_h4", cs4, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      frame_and_check(1'b0, vecs[i].tx, vecs[i].peri, vecs[i].word, vecs[i].exp_rx);
    end

    for (int i = 0; i < 6; i++) begin
      t = $urandom;
      w = $urandom;
      pm = 1'($urandom_range(0, 1));
      frame_and_check(1'b0, t, pm, w, pm ? w : t);
    end

    // Reset mid-frame.
    use4 = 1'b0;
    peri_mode = 1'b0;
    nd = 0;
    @(negedge clk);
    start8 = 1'b1;
    tx8 = 32'hCAFE_F00D;
    for (int n = 1; n <= 210; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) nd++;
      if (n == 200) begin
        check("mid_cs_low", cs8, 1'b0);
        rst_n = 1'b0;
      end
      if (n == 201) begin
        check("mid_rst_cs_n", cs8, 1'b1);
        check("mid_rst_sclk", sclk8, 1'b0);
        check("mid_rst_busy", busy8, 1'b0);
        check("mid_rst_rx", rx8, 32'h0);
        check("mid_rst_mosi", mosi8, 1'b0);
      end
      if (n == 203) rst_n = 1'b1;
    end
    check("mid_rst_no_done", nd, 0);
    frame_and_check(1'b0, 32'h0F0F_A55A, 1'b0, 32'h0, 32'h0F0F_A55A);

    // Back-to-back with start held high.
    @(negedge clk);
    start8 = 1'b1;
    tx8 = 32'h1357_9BDF;
    prev_cs = 1'b1; ncs = 0; csf2 = -1; nd = 0; d2 = -1; lo1 = -1; lo2 = -1;
    for (int n = 1; n <= 1200; n++) begin
      @(negedge clk);
      if (n == 1074) start8 = 1'b0;
      if (!cs8 && prev_cs) begin
        ncs++;
        if (ncs == 2) csf2 = n;
      end
      prev_cs = cs8;
      if (done8) begin
        nd++;
        if (nd == 2) d2 = n;
      end
      if (!busy8) begin
        if (lo1 < 0) lo1 = n;
        else if (lo2 < 0) lo2 = n;
      end
    end
    check("b2b_second_cs_fall", csf2, 538);
    check("b2b_cs_falls", ncs, 2);
    check("b2b_done_count", nd, 2);
    check("b2b_second_done", d2, 538 + 520);
    check("b2b_first_idle", lo1, 537);
    check("b2b_second_idle", lo2, 1074);
    check("b2b_rx", rx8, 32'h1357_9BDF);

    // Idle stability.
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (cs8 !== 1'b1 || sclk8 !== 1'b0 || mosi8 !== 1'b0 || done8 !== 1'b0) bad++;
    end
    check("idle_stable", bad, 0);

    // HALF=4, GAP=4 sweep.
    for (int i = 0; i < 4; i++) begin
      t = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      frame_and_check(1'b1, t, 1'b0, 32'h0, t);
    end
    for (int i = 0; i < 3; i++) begin
      t = $urandom;
      frame_and_check(1'b1, t, 1'b0, 32'h0, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
